// File: rtl/axi_wr_arb_pkg.sv
// rtl/axi_wr_arb_pkg.sv - shared FSM state type, AXI constants and pointer helper for axi_wr_arb
package axi_wr_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_RESP = 2'd3
   } state_e;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [2:0] SIZE_4B    = 3'b010;

   // Modulo-n increment used to advance the round-robin pointer past the last owner.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/axi_wr_arb_rr_arbiter.sv
// rtl/axi_wr_arb_rr_arbiter.sv - combinational round-robin pick: first requester at or after ptr_i
module axi_wr_arb_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               valid_o
);

   logic [IDX_W-1:0] cand;
   logic             found;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      cand    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
         if (!found && req_i[cand]) begin
            found         = 1'b1;
            grant_o[cand] = 1'b1;
            idx_o         = cand;
         end
      end
      valid_o = found;
   end

endmodule

// File: rtl/axi_wr_arb.sv
// rtl/axi_wr_arb.sv - round-robin AXI4 write-port arbiter, one whole AW/W/B transaction per grant
// Optional error counter enabled by defining AXI_WR_ARB_ERRCNT_EN.
module axi_wr_arb
   import axi_wr_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic [NUM_REQ*ADDR_W-1:0] s_awaddr_i,
   input  logic [NUM_REQ*4-1:0]      s_awlen_i,
   input  logic [NUM_REQ*3-1:0]      s_awsize_i,
   input  logic [NUM_REQ*2-1:0]      s_awburst_i,
   input  logic [NUM_REQ-1:0]        s_awvalid_i,
   output logic [NUM_REQ-1:0]        s_awready_o,
   input  logic [NUM_REQ*DATA_W-1:0] s_wdata_i,
   input  logic [NUM_REQ-1:0]        s_wlast_i,
   input  logic [NUM_REQ-1:0]        s_wvalid_i,
   output logic [NUM_REQ-1:0]        s_wready_o,
   output logic [1:0]                s_bresp_o,
   output logic [NUM_REQ-1:0]        s_bvalid_o,
   input  logic [NUM_REQ-1:0]        s_bready_i,
   output logic [ADDR_W-1:0]         m_awaddr_o,
   output logic [3:0]                m_awlen_o,
   output logic [2:0]                m_awsize_o,
   output logic [1:0]                m_awburst_o,
   output logic                      m_awvalid_o,
   input  logic                      m_awready_i,
   output logic [DATA_W-1:0]         m_wdata_o,
   output logic                      m_wlast_o,
   output logic                      m_wvalid_o,
   input  logic                      m_wready_i,
   input  logic [1:0]                m_bresp_i,
   input  logic                      m_bvalid_i,
   output logic                      m_bready_o,
   output logic [IDX_W-1:0]          grant_idx_o,
   output logic                      busy_o,
   output logic [15:0]               err_cnt_o
);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    grant_q, grant_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [3:0]          beat_cnt_q, beat_cnt_d;
   logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
   logic [3:0]          awlen_q, awlen_d;
   logic [2:0]          awsize_q, awsize_d;
   logic [1:0]          awburst_q, awburst_d;

   logic [NUM_REQ-1:0]  arb_grant;
   logic [IDX_W-1:0]    arb_idx;
   logic                arb_valid;
   logic                w_hs;
   logic                b_hs;

   axi_wr_arb_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .req_i   (s_awvalid_i),
      .ptr_i   (rr_ptr_q),
      .grant_o (arb_grant),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

   assign w_hs = m_wvalid_o && m_wready_i;
   assign b_hs = m_bvalid_i && m_bready_o;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (arb_valid)                state_d = ST_ADDR;
         ST_ADDR: if (m_awready_i)              state_d = ST_DATA;
         ST_DATA: if (w_hs && m_wlast_o)        state_d = ST_RESP;
         ST_RESP: if (b_hs)                     state_d = ST_IDLE;
         default:                               state_d = ST_IDLE;
      endcase
   end

   // W and B are steered combinationally from the owner so they add no latency.
   always_comb begin
      s_awready_o = '0;
      m_awvalid_o = 1'b0;
      m_wvalid_o  = 1'b0;
      m_wlast_o   = 1'b0;
      s_wready_o  = '0;
      s_bvalid_o  = '0;
      m_bready_o  = 1'b0;
      case (state_q)
         ST_IDLE: s_awready_o = arb_grant;
         ST_ADDR: m_awvalid_o = 1'b1;
         ST_DATA: begin
            m_wvalid_o          = s_wvalid_i[grant_q];
            m_wlast_o           = (beat_cnt_q == awlen_q);
            s_wready_o[grant_q] = m_wready_i;
         end
         ST_RESP: begin
            s_bvalid_o[grant_q] = m_bvalid_i;
            m_bready_o          = s_bready_i[grant_q];
         end
         default: ;
      endcase
   end

   always_comb begin
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      awaddr_d   = awaddr_q;
      awlen_d    = awlen_q;
      awsize_d   = awsize_q;
      awburst_d  = awburst_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               grant_d   = arb_idx;
               awaddr_d  = s_awaddr_i[arb_idx*ADDR_W +: ADDR_W];
               awlen_d   = s_awlen_i[arb_idx*4 +: 4];
               awsize_d  = s_awsize_i[arb_idx*3 +: 3];
               awburst_d = s_awburst_i[arb_idx*2 +: 2];
            end
         end
         ST_ADDR: if (m_awready_i) beat_cnt_d = '0;
         // The last beat leaves DATA, so the counter stops at awlen and never wraps.
         ST_DATA: if (w_hs && !m_wlast_o) beat_cnt_d = beat_cnt_q + 4'd1;
         ST_RESP: if (b_hs) rr_ptr_d = IDX_W'(wrap_inc(int'(grant_q), NUM_REQ));
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         awaddr_q   <= '0;
         awlen_q    <= '0;
         awsize_q   <= '0;
         awburst_q  <= '0;
      end else begin
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         awaddr_q   <= awaddr_d;
         awlen_q    <= awlen_d;
         awsize_q   <= awsize_d;
         awburst_q  <= awburst_d;
      end
   end

   assign m_awaddr_o  = awaddr_q;
   assign m_awlen_o   = awlen_q;
   assign m_awsize_o  = awsize_q;
   assign m_awburst_o = awburst_q;
   assign m_wdata_o   = s_wdata_i[grant_q*DATA_W +: DATA_W];
   assign s_bresp_o   = m_bresp_i;
   assign grant_idx_o = grant_q;
   assign busy_o      = (state_q != ST_IDLE);

`ifdef AXI_WR_ARB_ERRCNT_EN
   logic [15:0] err_cnt_q, err_cnt_d;
   logic [16:0] err_sum;

   // B error and last-beat mismatch are counted independently, so one cycle may add 2.
   always_comb begin
      err_sum   = {1'b0, err_cnt_q}
                + 17'(b_hs && (m_bresp_i != RESP_OKAY))
                + 17'(w_hs && (s_wlast_i[grant_q] != m_wlast_o));
      err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt_o = err_cnt_q;
`else
   logic unused_wlast;
   assign unused_wlast = ^s_wlast_i;
   assign err_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_axi_wr_arb.sv
// tb/tb_axi_wr_arb.sv - scoreboard bench for axi_wr_arb with directed requester/slave stimulus
module tb_axi_wr_arb;
   import axi_wr_arb_pkg::*;

   localparam int NR = 4;
   localparam int AW = 32;
   localparam int DW = 32;
`ifdef AXI_WR_ARB_ERRCNT_EN
   localparam logic [15:0] EXP_ERR = 16'd2;
`else
   localparam logic [15:0] EXP_ERR = 16'd0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [NR*AW-1:0] s_awaddr;
   logic [NR*4-1:0]  s_awlen;
   logic [NR*3-1:0]  s_awsize;
   logic [NR*2-1:0]  s_awburst;
   logic [NR-1:0]    s_awvalid, s_awready;
   logic [NR*DW-1:0] s_wdata;
   logic [NR-1:0]    s_wlast, s_wvalid, s_wready;
   logic [1:0]       s_bresp;
   logic [NR-1:0]    s_bvalid, s_bready;
   logic [AW-1:0]    m_awaddr;
   logic [3:0]       m_awlen;
   logic [2:0]       m_awsize;
   logic [1:0]       m_awburst;
   logic             m_awvalid, m_awready;
   logic [DW-1:0]    m_wdata;
   logic             m_wlast, m_wvalid, m_wready;
   logic [1:0]       m_bresp;
   logic             m_bvalid, m_bready;
   logic [1:0]       grant_idx;
   logic             busy;
   logic [15:0]      err_cnt;

   axi_wr_arb #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk_i(clk), .reset_i(reset),
      .s_awaddr_i(s_awaddr), .s_awlen_i(s_awlen), .s_awsize_i(s_awsize), .s_awburst_i(s_awburst),
      .s_awvalid_i(s_awvalid), .s_awready_o(s_awready),
      .s_wdata_i(s_wdata), .s_wlast_i(s_wlast), .s_wvalid_i(s_wvalid), .s_wready_o(s_wready),
      .s_bresp_o(s_bresp), .s_bvalid_o(s_bvalid), .s_bready_i(s_bready),
      .m_awaddr_o(m_awaddr), .m_awlen_o(m_awlen), .m_awsize_o(m_awsize), .m_awburst_o(m_awburst),
      .m_awvalid_o(m_awvalid), .m_awready_i(m_awready),
      .m_wdata_o(m_wdata), .m_wlast_o(m_wlast), .m_wvalid_o(m_wvalid), .m_wready_i(m_wready),
      .m_bresp_i(m_bresp), .m_bvalid_i(m_bvalid), .m_bready_o(m_bready),
      .grant_idx_o(grant_idx), .busy_o(busy), .err_cnt_o(err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; logic [3:0] len; int extra; } job_t;
   typedef struct { int idx; logic [31:0] addr; logic [3:0] len; } exp_aw_t;
   typedef struct { logic [31:0] data; logic last; } exp_w_t;
   typedef struct { int idx; logic [1:0] resp; } exp_b_t;

   job_t    jobq [NR][$];
   exp_aw_t exp_aw[$];
   exp_w_t  exp_w[$];
   exp_b_t  exp_b[$];
   logic [1:0] resp_q[$];

   int tests = 0;
   int fails = 0;
   int w_beats = 0;
   bit toggle = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic issue(input int r, input logic [31:0] addr, input logic [3:0] len, input int extra);
      jobq[r].push_back('{addr, len, extra});
   endtask

   task automatic expect_txn(input int idx, input logic [31:0] addr, input logic [3:0] len,
                             input logic [1:0] resp);
      exp_aw.push_back('{idx, addr, len});
      for (int b = 0; b <= int'(len); b++) exp_w.push_back('{addr + 32'(b), (b == int'(len))});
      exp_b.push_back('{idx, resp});
      resp_q.push_back(resp);
   endtask

   // Requester masters: W is offered together with AW so early data must stall.
   job_t cur [NR];
   int   beat [NR];
   int   phase [NR];
   logic [NR-1:0] aw_hs, w_hs, b_hs;

   task automatic drive_w(input int r);
      s_wdata[r*DW +: DW] = cur[r].addr + 32'(beat[r]);
      s_wlast[r]  = (beat[r] == int'(cur[r].len)) || (beat[r] == cur[r].extra);
      s_wvalid[r] = 1'b1;
   endtask

   function automatic bit all_idle();
      bit idle = (exp_aw.size() == 0) && (exp_w.size() == 0) && (exp_b.size() == 0) && !busy;
      for (int r = 0; r < NR; r++) if (jobq[r].size() != 0 || phase[r] != 0) idle = 1'b0;
      return idle;
   endfunction

   initial begin
      s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = '0;
      s_wdata = '0; s_wlast = '0; s_wvalid = '0; s_bready = '0;
      for (int r = 0; r < NR; r++) begin phase[r] = 0; beat[r] = 0; end
      forever begin
         @(negedge clk);
         aw_hs = s_awvalid & s_awready;
         w_hs  = s_wvalid & s_wready;
         b_hs  = s_bvalid & s_bready;
         @(posedge clk); #1;
         for (int r = 0; r < NR; r++) begin
            if (reset) begin
               phase[r] = 0; s_awvalid[r] = 1'b0; s_wvalid[r] = 1'b0;
               s_wlast[r] = 1'b0; s_bready[r] = 1'b0;
            end else begin
               case (phase[r])
                  0: if (jobq[r].size() > 0) begin
                     cur[r] = jobq[r].pop_front();
                     beat[r] = 0;
                     s_awaddr[r*AW +: AW] = cur[r].addr;
                     s_awlen[r*4 +: 4]    = cur[r].len;
                     s_awsize[r*3 +: 3]   = SIZE_4B;
                     s_awburst[r*2 +: 2]  = BURST_INCR;
                     s_awvalid[r] = 1'b1;
                     drive_w(r);
                     phase[r] = 1;
                  end
                  1: if (aw_hs[r]) begin s_awvalid[r] = 1'b0; phase[r] = 2; end
                  2: if (w_hs[r]) begin
                     if (beat[r] == int'(cur[r].len)) begin
                        s_wvalid[r] = 1'b0; s_wlast[r] = 1'b0; s_bready[r] = 1'b1; phase[r] = 3;
                     end else begin
                        beat[r]++;
                        drive_w(r);
                     end
                  end
                  3: if (b_hs[r]) begin s_bready[r] = 1'b0; phase[r] = 0; end
                  default: phase[r] = 0;
               endcase
            end
         end
      end
   end

   // Slave: AW always ready, optional toggling W ready, B one cycle after the last beat.
   logic sl_last, sl_b;
   initial begin
      m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0; m_bresp = 2'b00;
      forever begin
         @(negedge clk);
         sl_last = m_wvalid && m_wready && m_wlast;
         sl_b    = m_bvalid && m_bready;
         @(posedge clk); #1;
         if (reset) begin
            m_bvalid = 1'b0; m_wready = 1'b1;
         end else begin
            m_wready = toggle ? ~m_wready : 1'b1;
            if (sl_b) m_bvalid = 1'b0;
            if (sl_last) begin
               m_bvalid = 1'b1;
               if (resp_q.size() > 0) m_bresp = resp_q.pop_front();
               else m_bresp = 2'b00;
            end
         end
      end
   end

   exp_aw_t ea;
   exp_w_t  ew;
   exp_b_t  eb;
   always @(negedge clk) begin
      if (!reset) begin
         if (m_awvalid && m_awready) begin
            if (exp_aw.size() == 0) begin
               tests++; fails++;
               $display("FAIL aw_unexpected: got addr %h, required no AW", m_awaddr);
            end else begin
               ea = exp_aw.pop_front();
               check("aw_addr", m_awaddr, ea.addr);
               check("aw_len", 32'(m_awlen), 32'(ea.len));
               check("aw_grant", 32'(grant_idx), 32'(ea.idx));
               check("aw_size", 32'(m_awsize), 32'(SIZE_4B));
               check("aw_burst", 32'(m_awburst), 32'(BURST_INCR));
            end
         end
         if (m_wvalid)
            check("w_ready_route", 32'(s_wready), m_wready ? (32'd1 << grant_idx) : 32'd0);
         if (m_wvalid && m_wready) begin
            w_beats++;
            if (exp_w.size() == 0) begin
               tests++; fails++;
               $display("FAIL w_unexpected: got data %h, required no beat", m_wdata);
            end else begin
               ew = exp_w.pop_front();
               check("w_data", m_wdata, ew.data);
               check("w_last", 32'(m_wlast), 32'(ew.last));
            end
         end
         if ((s_bvalid & s_bready) != '0) begin
            if (exp_b.size() == 0) begin
               tests++; fails++;
               $display("FAIL b_unexpected: got bvalid %b, required none", s_bvalid);
            end else begin
               eb = exp_b.pop_front();
               check("b_owner", 32'(s_bvalid), 32'd1 << eb.idx);
               check("b_resp", 32'(s_bresp), 32'(eb.resp));
               check("b_mirror", 32'(m_bvalid), 32'd1);
            end
         end
      end
   end

   task automatic wait_done(input string name);
      int n = 0;
      do begin @(negedge clk); n++; end while (!all_idle() && n < 3000);
      check(name, 32'(n < 3000), 32'd1);
      check({name, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic check_quiet(input string tag, input logic [1:0] gidx);
      check({tag, "_m_awvalid"}, 32'(m_awvalid), 32'd0);
      check({tag, "_m_wvalid"}, 32'(m_wvalid), 32'd0);
      check({tag, "_m_bready"}, 32'(m_bready), 32'd0);
      check({tag, "_s_awready"}, 32'(s_awready), 32'd0);
      check({tag, "_s_wready"}, 32'(s_wready), 32'd0);
      check({tag, "_s_bvalid"}, 32'(s_bvalid), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_grant_idx"}, 32'(grant_idx), 32'(gidx));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no completion, required summary");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_quiet("reset", 2'd0);
      check("reset_err_cnt", 32'(err_cnt), 32'd0);
      @(posedge clk); #1 reset = 1'b0;

      // Single 16-beat burst from requester 0; AW appears one cycle after s_awready.
      expect_txn(0, 32'h100, 4'd15, RESP_OKAY);
      issue(0, 32'h100, 4'd15, -1);
      n = 0;
      do begin @(negedge clk); n++; end while (!s_awready[0] && n < 50);
      check("t1_awready_seen", 32'(n < 50), 32'd1);
      @(negedge clk);
      check("t1_awvalid", 32'(m_awvalid), 32'd1);
      check("t1_awaddr", m_awaddr, 32'h100);
      wait_done("t1_done");

      // All four request together from reset: grants 0,1,2,3,0.
      @(posedge clk); #1 reset = 1'b1;
      repeat (2) @(posedge clk); #1;
      issue(0, 32'h1000, 4'd1, -1);
      issue(1, 32'h2000, 4'd1, -1);
      issue(2, 32'h3000, 4'd1, -1);
      issue(3, 32'h4000, 4'd1, -1);
      issue(0, 32'h5000, 4'd1, -1);
      expect_txn(0, 32'h1000, 4'd1, RESP_OKAY);
      expect_txn(1, 32'h2000, 4'd1, RESP_OKAY);
      expect_txn(2, 32'h3000, 4'd1, RESP_OKAY);
      expect_txn(3, 32'h4000, 4'd1, RESP_OKAY);
      expect_txn(0, 32'h5000, 4'd1, RESP_OKAY);
      reset = 1'b0;
      wait_done("t2_rr_order");

      // Toggling slave W ready, len 3 from requester 1.
      toggle = 1'b1;
      expect_txn(1, 32'h6000, 4'd3, RESP_OKAY);
      issue(1, 32'h6000, 4'd3, -1);
      wait_done("t3_toggle");
      toggle = 1'b0;

      // SLVERR response plus an extra s_wlast on beat 2 of a len 3 burst.
      expect_txn(2, 32'h7000, 4'd3, 2'b10);
      issue(2, 32'h7000, 4'd3, 1);
      wait_done("t4_errors");
      check("t4_err_cnt", 32'(err_cnt), 32'(EXP_ERR));

      // rr_ptr is 3 after the grant to 2: 2 alone wraps to 2, then 3 beats 0.
      expect_txn(2, 32'h8000, 4'd0, RESP_OKAY);
      issue(2, 32'h8000, 4'd0, -1);
      wait_done("t6_wrap");
      expect_txn(3, 32'h9000, 4'd0, RESP_OKAY);
      expect_txn(0, 32'hA000, 4'd0, RESP_OKAY);
      issue(3, 32'h9000, 4'd0, -1);
      issue(0, 32'hA000, 4'd0, -1);
      wait_done("t6_ptr_after_wrap");

      // Reset in the middle of a 16-beat burst from requester 3.
      expect_txn(3, 32'hB000, 4'd15, RESP_OKAY);
      issue(3, 32'hB000, 4'd15, -1);
      n = 0;
      begin
         int base = w_beats;
         do begin @(negedge clk); n++; end while (w_beats < base + 5 && n < 500);
      end
      check("t5_reach_beat5", 32'(n < 500), 32'd1);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_quiet("t5_midreset", 2'd0);
      exp_aw.delete(); exp_w.delete(); exp_b.delete(); resp_q.delete();
      @(posedge clk); #1 reset = 1'b0;
      expect_txn(0, 32'hC000, 4'd2, RESP_OKAY);
      expect_txn(3, 32'hD000, 4'd0, RESP_OKAY);
      issue(0, 32'hC000, 4'd2, -1);
      issue(3, 32'hD000, 4'd0, -1);
      wait_done("t5_after_reset");

      check("sb_drained", 32'(exp_aw.size() + exp_w.size() + exp_b.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/axi_wr_arb.md
# axi_wr_arb

Round-robin arbiter that shares one AXI4 write port (AW/W/B) among NUM_REQ requesters, each an AXI write master such as the 16-beat INCR burst writer. Grants one whole transaction at a time (address, all data beats, response) so bursts never interleave on the downstream port. Sits between the write masters and the single memory/interconnect slave port.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- ADDR_W, 32: address width
- DATA_W, 32: data width
- IDX_W, $clog2(NUM_REQ): grant index width

- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- s_awaddr / s_awlen / s_awsize / s_awburst  in  NUM_REQ*ADDR_W / NUM_REQ*4 / NUM_REQ*3 / NUM_REQ*2  per-requester AW fields, requester i at slice i
- s_awvalid  in  NUM_REQ;  s_awready  out  NUM_REQ
- s_wdata  in  NUM_REQ*DATA_W;  s_wlast, s_wvalid  in  NUM_REQ;  s_wready  out  NUM_REQ
- s_bresp  out  2  response, shared by all requesters;  s_bvalid  out  NUM_REQ;  s_bready  in  NUM_REQ
- m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid  out  widths as above;  m_awready  in  1
- m_wdata, m_wlast, m_wvalid  out  DATA_W/1/1;  m_wready  in  1
- m_bresp  in  2;  m_bvalid  in  1;  m_bready  out  1
- grant_idx  out  IDX_W  current owner;  busy  out  1  high outside IDLE
- err_cnt  out  16  error counter (see Configuration)

## Operation
- FSM: IDLE -> ADDR -> DATA -> RESP -> IDLE.
- IDLE: the round-robin pick starts at rr_ptr and takes the first i with s_awvalid[i]. s_awready[g]=1 combinationally for one cycle. AW fields latch into registers and grant_idx<=g. Next state is ADDR.
- ADDR: m_awvalid=1 with the latched fields. On m_awready, go to DATA and load beat_cnt=0.
- DATA: pure combinational pass-through from the granted requester: m_wdata=s_wdata[g], m_wvalid=s_wvalid[g], s_wready[g]=m_wready. All other s_wready are 0. m_wlast=(beat_cnt==awlen_q), generated locally; s_wlast is only checked, never forwarded. Each m_wvalid&&m_wready increments beat_cnt (4-bit). The handshake with m_wlast=1 moves the FSM to RESP.
- RESP: s_bvalid[g]=m_bvalid, m_bready=s_bready[g], s_bresp=m_bresp. On handshake: rr_ptr<=(g+1) mod NUM_REQ, then IDLE.
- Non-granted requesters see all readies and s_bvalid at 0.
- Write data is accepted only after the AW handshake downstream. Requesters that drive W before AW completes simply stall.
- Reset: all m_*valid, s_*ready, s_bvalid, m_bready, busy are 0. grant_idx=0, rr_ptr=0, beat_cnt=0, err_cnt=0, FSM in IDLE.
- Reset mid-transaction abandons the burst. No recovery is attempted; the downstream slave is reset with the same signal.

## Timing
- Arbitration to m_awvalid: 1 cycle (registered AW). A new AW cannot issue before the previous B handshake completes.
- Minimum transaction with zero-wait slave and len=0: IDLE 1 + ADDR 1 + DATA 1 + RESP 1 = 4 cycles.
- W and B paths add 0 cycles of latency (combinational).
- Simultaneous requests: the lowest index at or after rr_ptr wins. The winner gets the next grant only after every other active requester has had a turn.
- m_awvalid is held stable until m_awready, with fields unchanged (AXI rule).
- awlen=15 produces exactly 16 beats. The beat counter never wraps because the FSM leaves DATA at beat 15.

## Configuration
- AXI_WR_ARB_ERRCNT_EN defined: err_cnt is a 16-bit saturating counter (stops at 16'hFFFF). It increments once per B handshake with m_bresp!=2'b00. It also increments once per W beat where s_wlast[g]!=m_wlast (last-beat mismatch). If both occur in the same cycle, it adds 2.
- Not defined: err_cnt is tied to 0 and no counter logic is synthesized.

## Structure
- Package axi_wr_arb_pkg: FSM state enum (IDLE, ADDR, DATA, RESP), AXI constants (BURST_INCR=2'b01, RESP_OKAY=2'b00, SIZE_4B=3'b010).
- Sub-module rr_arbiter: inputs req[NUM_REQ] and ptr; outputs one-hot grant and index. It is purely combinational; rr_ptr lives in the parent.

## Test plan
- Single requester 0, awaddr=0x100, awlen=15: m_awaddr=0x100 one cycle after s_awready[0]. Exactly 16 W beats are forwarded, with m_wlast only on beat 16. s_bvalid[0] mirrors m_bvalid. Then back to IDLE.
- All 4 requesters hold awvalid continuously from reset: grants come in order 0,1,2,3,0. No W beats from different requesters interleave.
- Slave m_wready toggles every other cycle, len=3: exactly 4 beats transfer with data unchanged. s_wready of the owner matches m_wready; others stay 0.
- With the macro defined, m_bresp=2'b10 on one burst and s_wlast asserted on beat 2 of a len=3 burst: err_cnt=2. Without the macro, err_cnt=0.
- Assert reset in DATA at beat 5: the next cycle shows all valids/readies 0, busy=0, grant_idx=0. After release, requester 0 wins first.
- Requester 2 alone with rr_ptr=3 after a prior grant to 2: the wrap-around pick selects 2 and rr_ptr becomes 3.
